// File: rtl/space_ctrl_pkg.sv
// rtl/space_ctrl_pkg.sv - shared types and constants for the peripheral bus arbiter
package space_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_e;

  typedef enum logic {
    GNT_WB,
    GNT_LA
  } grant_e;

  // Read data returned to the host when the peripheral never answers
  localparam logic [31:0] TIMEOUT_DATA      = 32'hDEAD_0BAD;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;

endpackage

// File: rtl/bus_timeout_timer.sv
// rtl/bus_timeout_timer.sv - loadable down-counter flagging a stalled downstream transaction
module bus_timeout_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  input  logic en,
  output logic expired
);

  // Loading TIMEOUT-1 makes expired rise on the TIMEOUT-th enabled cycle
  localparam logic [15:0] LOAD_VAL = 16'(TIMEOUT - 1);

  logic [15:0] count;
  logic        armed;

  // Counter: clear disarms, load arms, enable counts down and parks at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      armed <= 1'b0;
    end else if (clear) begin
      count <= '0;
      armed <= 1'b0;
    end else if (load) begin
      count <= LOAD_VAL;
      armed <= 1'b1;
    end else if (en && (count != '0)) begin
      count <= count - 16'd1;
    end
  end

  assign expired = armed && (count == '0);

endmodule

// File: rtl/wb_la_bus_arbiter.sv
// rtl/wb_la_bus_arbiter.sv - shares the peripheral bus between Wishbone and LA hosts
module wb_la_bus_arbiter
  import space_ctrl_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          TIMEOUT   = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  input  logic              la_req_i,
  input  logic              la_we_i,
  input  logic [ADDR_W-1:0] la_adr_i,
  input  logic [31:0]       la_dat_i,
  output logic [31:0]       la_dat_o,
  output logic              la_done_o,
  output logic              la_err_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [3:0]        m_sel_o,
  output logic [ADDR_W-1:0] m_adr_o,
  output logic [31:0]       m_wdat_o,
  input  logic [31:0]       m_rdat_i,
  input  logic              m_ack_i,
  output logic              timeout_flag_o
);

  localparam int HI = ADDR_W + 2;

  arb_state_e  state, state_d;
  grant_e      grant, last_grant;
  logic        la_req_q, la_pend;
  logic        hit, wb_pend, wb_miss, la_rise;
  logic        take_wb, take_la, bus_done, bus_timeout, expired;
  logic [31:0] resp_data;
  logic        unused_adr;

  // Byte-lane bits of the Wishbone address never reach the word-addressed bus
  assign unused_adr = &{1'b0, wbs_adr_i[1:0]};

  assign hit       = (wbs_adr_i[31:HI] == BASE_ADDR[31:HI]);
  assign wb_pend   = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
  assign wb_miss   = wbs_cyc_i & wbs_stb_i & ~hit & ~wbs_ack_o & (state == IDLE);
  assign la_rise   = la_req_i & ~la_req_q;
  assign m_req_o   = (state == ISSUE);
  assign resp_data = bus_done ? m_rdat_i : TIMEOUT_DATA;

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= IDLE;
    else             state <= state_d;
  end

  // Next state: round-robin grant in IDLE, ack-or-timeout completion in ISSUE
  always_comb begin
    state_d     = state;
    take_wb     = 1'b0;
    take_la     = 1'b0;
    bus_done    = 1'b0;
    bus_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (wb_pend && (!la_pend || (last_grant == GNT_LA))) begin
          take_wb = 1'b1;
          state_d = ISSUE;
        end else if (la_pend) begin
          take_la = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (m_ack_i) begin
          bus_done = 1'b1;
          state_d  = RESP;
        end else if (expired) begin
          bus_timeout = 1'b1;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  bus_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n_i),
    .load    (take_wb | take_la),
    .clear   (bus_done | bus_timeout),
    .en      (state == ISSUE),
    .expired (expired)
  );

  // LA request edge detection and pending flag, released once its result is posted
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      la_req_q <= 1'b0;
      la_pend  <= 1'b0;
    end else begin
      la_req_q <= la_req_i;
      if (la_rise)                                  la_pend <= 1'b1;
      else if ((state == RESP) && (grant == GNT_LA)) la_pend <= 1'b0;
    end
  end

  // Latch the winner's command so m_* stay stable for the whole ISSUE phase
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      grant      <= GNT_WB;
      last_grant <= GNT_LA;
      m_we_o     <= 1'b0;
      m_sel_o    <= '0;
      m_adr_o    <= '0;
      m_wdat_o   <= '0;
    end else if (take_wb) begin
      grant      <= GNT_WB;
      last_grant <= GNT_WB;
      m_we_o     <= wbs_we_i;
      m_sel_o    <= wbs_sel_i;
      m_adr_o    <= wbs_adr_i[HI-1:2];
      m_wdat_o   <= wbs_dat_i;
    end else if (take_la) begin
      grant      <= GNT_LA;
      last_grant <= GNT_LA;
      m_we_o     <= la_we_i;
      m_sel_o    <= 4'hF;
      m_adr_o    <= la_adr_i;
      m_wdat_o   <= la_dat_i;
    end
  end

  // Responses: one-cycle Wishbone ack, LA done/err held until the request drops
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wbs_ack_o      <= 1'b0;
      wbs_dat_o      <= '0;
      la_dat_o       <= '0;
      la_done_o      <= 1'b0;
      la_err_o       <= 1'b0;
      timeout_flag_o <= 1'b0;
    end else begin
      wbs_ack_o <= wb_miss;
      wbs_dat_o <= '0;
      if (la_done_o && !la_req_i) begin
        la_done_o <= 1'b0;
        la_err_o  <= 1'b0;
      end
      if (bus_done || bus_timeout) begin
        if (grant == GNT_WB) begin
          wbs_ack_o <= 1'b1;
          wbs_dat_o <= resp_data;
        end else begin
          la_dat_o  <= resp_data;
          la_done_o <= 1'b1;
          la_err_o  <= bus_timeout;
        end
      end
      if (bus_timeout) timeout_flag_o <= 1'b1;
    end
  end

endmodule
